// File: rtl/dcnn_pkg.sv
// rtl/dcnn_pkg.sv - shared types and helpers for the dcnn stage-1 ingress
package dcnn_pkg;

  typedef enum logic [1:0] {IDLE, CFG, KLOAD, RUN} s1_ingress_state_t;

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dcnn_lane_fifo.sv
// rtl/dcnn_lane_fifo.sv - per-lane FIFO with occupancy count and synchronous flush
module dcnn_lane_fifo
  import dcnn_pkg::*;
#(
  parameter int DW = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int PW = fifo_ptr_w(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [PW:0]   count,
  output logic          empty
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, wr_en, rd_en;

  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign rd_en    = pop & ~empty;
  // A full FIFO may still take a push in the same cycle it is popped.
  assign wr_en    = push & (~full | rd_en);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dcnn_s1_ingress.sv
// rtl/dcnn_s1_ingress.sv - stage-1 lane-aligned ingress and phase sequencer (DCNN_S1_INGRESS_PERF_EN adds stall counters)
module dcnn_s1_ingress
  import dcnn_pkg::*;
#(
  parameter int DW = 32,
  parameter int LANES = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int K_BITS = 4,
  parameter int M_BITS = 10
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                start,
  input  logic                abort,
  input  logic [K_BITS-1:0]   k_size,
  input  logic [M_BITS-1:0]   m_size,
  input  logic [M_BITS-1:0]   n_rows,
  input  logic [LANES-1:0]    img_vld,
  input  logic [LANES*DW-1:0] img_data,
  output logic [LANES-1:0]    img_rdy,
  output logic                chain_cfg,
  input  logic                chain_cfg_done,
  output logic                kernel_load,
  output logic [LANES-1:0]    chain_vld,
  output logic [LANES*DW-1:0] chain_data,
  input  logic                chain_stall,
  output logic                row_done,
  output logic                frame_done,
  output logic                busy
`ifdef DCNN_S1_INGRESS_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [LANES-1:0]    lane_starve
`endif
);

  localparam int CW = fifo_ptr_w(FIFO_DEPTH);
  localparam int KW = 2 * K_BITS;

  s1_ingress_state_t   state;
  logic [K_BITS-1:0]   k_cap;
  logic [M_BITS-1:0]   m_cap, n_cap, col, row;
  logic [KW-1:0]       kcnt, k_sq;
  logic [LANES-1:0]    lane_empty;
  logic [CW:0]         lane_count [LANES];
  logic [LANES*DW-1:0] pop_bus;
  logic                all_ready, run_ok, go, pop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dcnn_lane_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .arst      (arst),
      .flush     (abort),
      .push      (img_vld[i] & img_rdy[i]),
      .push_data (img_data[i*DW +: DW]),
      .pop       (pop),
      .pop_data  (pop_bus[i*DW +: DW]),
      .count     (lane_count[i]),
      .empty     (lane_empty[i])
    );
    assign img_rdy[i] = (lane_count[i] < (CW+1)'(FIFO_DEPTH));
  end

  assign k_sq      = KW'(k_cap) * KW'(k_cap);
  assign all_ready = &(~lane_empty);
  assign run_ok    = (m_cap != '0) && (n_cap != '0);
  // A degenerate frame must not consume beats on its way back to IDLE.
  assign go        = !chain_stall && all_ready && ((state == KLOAD) || (state == RUN && run_ok));
  assign pop       = go & ~abort;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      k_cap       <= '0;
      m_cap       <= '0;
      n_cap       <= '0;
      kcnt        <= '0;
      col         <= '0;
      row         <= '0;
      chain_cfg   <= 1'b0;
      kernel_load <= 1'b0;
      chain_vld   <= '0;
      chain_data  <= '0;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      chain_vld   <= {LANES{pop}};
      kernel_load <= pop && (state == KLOAD);
      if (pop) chain_data <= pop_bus;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        kcnt      <= '0;
        col       <= '0;
        row       <= '0;
        chain_cfg <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            k_cap     <= k_size;
            m_cap     <= m_size;
            n_cap     <= n_rows;
            chain_cfg <= 1'b1;
            state     <= CFG;
          end
          CFG: if (chain_cfg_done) begin
            chain_cfg <= 1'b0;
            state     <= (k_cap == '0) ? RUN : KLOAD;
          end
          KLOAD: if (pop) begin
            if (kcnt == k_sq - KW'(1)) begin
              kcnt  <= '0;
              state <= RUN;
            end else begin
              kcnt <= kcnt + KW'(1);
            end
          end
          RUN: if (!run_ok) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else if (pop) begin
            if (col == m_cap - M_BITS'(1)) begin
              col      <= '0;
              row_done <= 1'b1;
              if (row == n_cap - M_BITS'(1)) begin
                row        <= '0;
                state      <= IDLE;
                frame_done <= 1'b1;
              end else begin
                row <= row + M_BITS'(1);
              end
            end else begin
              col <= col + M_BITS'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DCNN_S1_INGRESS_PERF_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cycles <= '0;
      lane_starve  <= '0;
    end else begin
      lane_starve <= lane_empty;
      if (state == IDLE && start && !abort)
        stall_cycles <= '0;
      else if ((state == KLOAD || state == RUN) && !go && (chain_stall || !all_ready)
               && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcnn_s1_ingress.sv
// tb/tb_dcnn_s1_ingress.sv - directed self-checking bench for dcnn_s1_ingress
module tb_dcnn_s1_ingress;

  localparam int DW = 32;
  localparam int LANES = 2;
  localparam int KB = 4;
  localparam int MB = 10;

  logic                clk = 1'b0;
  logic                arst, start, abort, chain_cfg_done, chain_stall;
  logic [KB-1:0]       k_size;
  logic [MB-1:0]       m_size, n_rows;
  logic [LANES-1:0]    img_vld, img_rdy, chain_vld;
  logic [LANES*DW-1:0] img_data, chain_data;
  logic                chain_cfg, kernel_load, row_done, frame_done, busy;
`ifdef DCNN_S1_INGRESS_PERF_EN
  logic [31:0]         stall_cycles;
  logic [LANES-1:0]    lane_starve;
`endif

  int               vec, errs, out_idx;
  int               seq [LANES];
  logic [LANES-1:0] src_en;

  dcnn_s1_ingress #(.DW(DW), .LANES(LANES), .FIFO_DEPTH(4), .K_BITS(KB), .M_BITS(MB)) dut (
    .clk            (clk),
    .arst           (arst),
    .start          (start),
    .abort          (abort),
    .k_size         (k_size),
    .m_size         (m_size),
    .n_rows         (n_rows),
    .img_vld        (img_vld),
    .img_data       (img_data),
    .img_rdy        (img_rdy),
    .chain_cfg      (chain_cfg),
    .chain_cfg_done (chain_cfg_done),
    .kernel_load    (kernel_load),
    .chain_vld      (chain_vld),
    .chain_data     (chain_data),
    .chain_stall    (chain_stall),
    .row_done       (row_done),
    .frame_done     (frame_done),
    .busy           (busy)
`ifdef DCNN_S1_INGRESS_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .lane_starve    (lane_starve)
`endif
  );

  always #5 clk = ~clk;

  // lane 0 words are 0x1000_0000+n, lane 1 words 0x2000_0000+n
  function automatic logic [DW-1:0] lane_word(input int lane, input int idx);
    return DW'(((lane + 1) << 28) + idx);
  endfunction

  function automatic logic [LANES*DW-1:0] exp_beat(input int idx);
    logic [LANES*DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = lane_word(i, idx);
    return d;
  endfunction

  task automatic drive_step();
    logic [LANES-1:0] acc;
    img_vld = src_en;
    for (int i = 0; i < LANES; i++) img_data[i*DW +: DW] = lane_word(i, seq[i]);
    acc = img_vld & img_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < LANES; i++) if (acc[i]) seq[i]++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vec++; if (chain_vld !== '0) begin errs++; $display("FAIL reset_vld: got %b expected 00", chain_vld); end
    vec++; if (chain_data !== '0) begin errs++; $display("FAIL reset_data: got %h expected 0", chain_data); end
    vec++; if ({chain_cfg, kernel_load, row_done, frame_done, busy} !== 5'b0) begin
      errs++; $display("FAIL reset_ctl: got %b expected 00000", {chain_cfg, kernel_load, row_done, frame_done, busy});
    end
    arst = 1'b0;
    @(posedge clk);
    #1;
    vec++; if (img_rdy !== 2'b11) begin errs++; $display("FAIL reset_rdy: got %b expected 11", img_rdy); end
  endtask

  task automatic test_stream_frame();
    int beats;
    bit fd;
    beats = 0; fd = 0;
    k_size = 3; m_size = 4; n_rows = 2; src_en = 2'b11; start = 1'b1;
    drive_step();
    start = 1'b0;
    vec++; if (chain_cfg !== 1'b1) begin errs++; $display("FAIL frame_cfg: got %b expected 1", chain_cfg); end
    for (int c = 0; c < 80 && !fd; c++) begin
      if (chain_vld !== '0) begin
        vec++; if (chain_vld !== 2'b11) begin errs++; $display("FAIL frame_vld: got %b expected 11", chain_vld); end
        vec++; if (chain_data !== exp_beat(out_idx)) begin errs++; $display("FAIL frame_data: got %h expected %h", chain_data, exp_beat(out_idx)); end
        vec++; if (kernel_load !== (beats < 9)) begin errs++; $display("FAIL frame_kload beat %0d: got %b expected %b", beats, kernel_load, beats < 9); end
        vec++; if (row_done !== (beats == 12 || beats == 16)) begin errs++; $display("FAIL frame_row beat %0d: got %b", beats, row_done); end
        vec++; if (frame_done !== (beats == 16)) begin errs++; $display("FAIL frame_done beat %0d: got %b", beats, frame_done); end
        if (frame_done === 1'b1) fd = 1;
        out_idx++; beats++;
      end else begin
        vec++; if ((row_done | frame_done) !== 1'b0) begin errs++; $display("FAIL frame_idle_pulse: got %b%b expected 00", row_done, frame_done); end
      end
      if (!fd) drive_step();
    end
    vec++; if (beats != 17) begin errs++; $display("FAIL frame_beats: got %0d expected 17", beats); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL frame_busy: got %b expected 0", busy); end
  endtask

  task automatic test_lane_starve();
    int beats, hold_left;
    bit fd, held, drop;
    beats = 0; fd = 0; held = 0; drop = 0; hold_left = 0;
    k_size = 1; m_size = 8; n_rows = 2; src_en = 2'b11; start = 1'b1;
    drive_step();
    start = 1'b0;
    for (int c = 0; c < 100 && !fd; c++) begin
      if (chain_vld !== '0) begin
        vec++; if (chain_vld !== 2'b11) begin errs++; $display("FAIL starve_vld: got %b expected 11", chain_vld); end
        vec++; if (chain_data !== exp_beat(out_idx)) begin errs++; $display("FAIL starve_data: got %h expected %h", chain_data, exp_beat(out_idx)); end
        vec++; if (row_done !== (beats == 8 || beats == 16)) begin errs++; $display("FAIL starve_row beat %0d: got %b", beats, row_done); end
        if (frame_done === 1'b1) fd = 1;
        out_idx++; beats++;
      end
      if (!fd) begin
        if (beats == 5 && !held) begin held = 1; hold_left = 5; end
        src_en = (hold_left > 0) ? 2'b01 : 2'b11;
        drive_step();
        if (hold_left > 0) begin
          if (img_rdy[0] === 1'b0) drop = 1;
          hold_left--;
          if (hold_left == 0) begin
            vec++; if (chain_vld !== '0) begin errs++; $display("FAIL starve_gap: got %b expected 00", chain_vld); end
          end
        end
      end
    end
    src_en = 2'b11;
    vec++; if (drop != 1) begin errs++; $display("FAIL starve_rdy0_drop: got %0d expected 1", drop); end
    vec++; if (beats != 17) begin errs++; $display("FAIL starve_beats: got %0d expected 17", beats); end
  endtask

  task automatic test_stall();
    int beats;
    bit fd;
    beats = 0; fd = 0; src_en = 2'b11; chain_stall = 1'b0;
    repeat (6) drive_step();
    vec++; if (img_rdy !== 2'b00) begin errs++; $display("FAIL prefill_rdy: got %b expected 00", img_rdy); end
    vec++; if ({chain_vld, busy} !== 3'b000) begin errs++; $display("FAIL prefill_idle: got %b expected 000", {chain_vld, busy}); end
    k_size = 0; m_size = 4; n_rows = 2; start = 1'b1;
    drive_step();
    start = 1'b0;
    drive_step();
    for (int c = 2; c < 60 && !fd; c++) begin
      chain_stall = (c % 2 == 0);
      drive_step();
      if (chain_vld !== '0) begin
        vec++; if (chain_stall !== 1'b0) begin errs++; $display("FAIL stall_gap: got beat with stall=%b expected 0", chain_stall); end
        vec++; if (chain_data !== exp_beat(out_idx)) begin errs++; $display("FAIL stall_data: got %h expected %h", chain_data, exp_beat(out_idx)); end
        vec++; if (kernel_load !== 1'b0) begin errs++; $display("FAIL stall_kload: got %b expected 0", kernel_load); end
        vec++; if (row_done !== (beats == 3 || beats == 7)) begin errs++; $display("FAIL stall_row beat %0d: got %b", beats, row_done); end
        if (frame_done === 1'b1) fd = 1;
        out_idx++; beats++;
      end
    end
    chain_stall = 1'b0;
    vec++; if (beats != 8) begin errs++; $display("FAIL stall_beats: got %0d expected 8", beats); end
`ifdef DCNN_S1_INGRESS_PERF_EN
    vec++; if (stall_cycles !== 32'd8) begin errs++; $display("FAIL stall_count: got %0d expected 8", stall_cycles); end
`endif
  endtask

  task automatic test_zero_size();
    k_size = 0; m_size = 0; n_rows = 2; src_en = 2'b11; start = 1'b1;
    drive_step();
    start = 1'b0;
    vec++; if ({chain_cfg, busy} !== 2'b11) begin errs++; $display("FAIL zero_cfg_on: got %b expected 11", {chain_cfg, busy}); end
    drive_step();
    vec++; if ({chain_cfg, busy, chain_vld} !== 4'b0100) begin errs++; $display("FAIL zero_run: got %b expected 0100", {chain_cfg, busy, chain_vld}); end
    drive_step();
    vec++; if ({frame_done, row_done, chain_vld, busy} !== 5'b10000) begin
      errs++; $display("FAIL zero_done: got %b expected 10000", {frame_done, row_done, chain_vld, busy});
    end
    drive_step();
    vec++; if ({frame_done, chain_vld} !== 3'b000) begin errs++; $display("FAIL zero_after: got %b expected 000", {frame_done, chain_vld}); end
  endtask

  task automatic test_abort();
    int beats;
    beats = 0;
    k_size = 3; m_size = 4; n_rows = 2; src_en = 2'b11; start = 1'b1;
    drive_step();
    start = 1'b0;
    for (int c = 0; c < 40 && beats < 5; c++) begin
      if (chain_vld !== '0) begin
        vec++; if (chain_data !== exp_beat(out_idx)) begin errs++; $display("FAIL abort_data: got %h expected %h", chain_data, exp_beat(out_idx)); end
        vec++; if (kernel_load !== 1'b1) begin errs++; $display("FAIL abort_kload: got %b expected 1", kernel_load); end
        out_idx++; beats++;
      end
      if (beats < 5) drive_step();
    end
    vec++; if (beats != 5) begin errs++; $display("FAIL abort_pre_beats: got %0d expected 5", beats); end
    abort = 1'b1; src_en = 2'b00;
    drive_step();
    abort = 1'b0;
    vec++; if ({busy, chain_vld, frame_done} !== 4'b0000) begin errs++; $display("FAIL abort_idle: got %b expected 0000", {busy, chain_vld, frame_done}); end
    drive_step();
    vec++; if (img_rdy !== 2'b11) begin errs++; $display("FAIL abort_rdy: got %b expected 11", img_rdy); end
    vec++; if ({frame_done, busy} !== 2'b00) begin errs++; $display("FAIL abort_nodone: got %b expected 00", {frame_done, busy}); end
    out_idx = 1000;
    for (int i = 0; i < LANES; i++) seq[i] = 1000;
    test_stream_frame();
  endtask

  task automatic test_reset_mid_run();
    int beats;
    beats = 0;
    k_size = 0; m_size = 8; n_rows = 2; src_en = 2'b11; start = 1'b1;
    drive_step();
    start = 1'b0;
    for (int c = 0; c < 30 && beats < 3; c++) begin
      drive_step();
      if (chain_vld !== '0) begin
        vec++; if (chain_data !== exp_beat(out_idx)) begin errs++; $display("FAIL rst_run_data: got %h expected %h", chain_data, exp_beat(out_idx)); end
        out_idx++; beats++;
      end
    end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL rst_run_busy: got %b expected 1", busy); end
    arst = 1'b1; src_en = 2'b00; img_vld = 2'b00;
    #1;
    vec++; if ({chain_vld, chain_cfg, kernel_load, row_done, frame_done, busy} !== 7'b0) begin
      errs++; $display("FAIL rst_mid_ctl: got %b expected 0000000", {chain_vld, chain_cfg, kernel_load, row_done, frame_done, busy});
    end
    vec++; if (chain_data !== '0) begin errs++; $display("FAIL rst_mid_data: got %h expected 0", chain_data); end
`ifdef DCNN_S1_INGRESS_PERF_EN
    vec++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL rst_mid_perf: got %0d expected 0", stall_cycles); end
`endif
    @(posedge clk);
    #1;
    vec++; if ({busy, chain_vld} !== 3'b000) begin errs++; $display("FAIL rst_hold: got %b expected 000", {busy, chain_vld}); end
    arst = 1'b0;
    drive_step();
    vec++; if (img_rdy !== 2'b11) begin errs++; $display("FAIL rst_mid_rdy: got %b expected 11", img_rdy); end
  endtask

  initial begin
    vec = 0; errs = 0; out_idx = 0;
    for (int i = 0; i < LANES; i++) seq[i] = 0;
    arst = 1'b1; start = 1'b0; abort = 1'b0; chain_cfg_done = 1'b0; chain_stall = 1'b0;
    k_size = '0; m_size = '0; n_rows = '0; img_vld = '0; img_data = '0; src_en = '0;
    test_reset();
    chain_cfg_done = 1'b1;
    test_stream_frame();
    test_lane_starve();
    test_stall();
    test_zero_size();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/dcnn_s1_ingress.md
# dcnn_s1_ingress

Parametrised front end of the stage-1 PE chain. It replaces the hard-wired always-ready two-stream image input with LANES independently back-pressured streams, each buffered in a small FIFO. It pops all lanes in lock-step only when every lane has data, and sequences the chain through configure, kernel-load and run phases with row and frame accounting. It sits between the stage-0 stream generator and the stage-1 PE chain.

## Interface
- DW, 32, data width per lane
- LANES, 2, number of parallel image streams (≥1)
- FIFO_DEPTH, 4, entries per lane FIFO (power of two, ≥2)
- K_BITS, 4, kernel-size width
- M_BITS, 10, row-length / row-count width

- clk  in  1  clock
- arst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; captures k_size, m_size, n_rows; ignored unless IDLE
- abort  in  1  synchronous; returns to IDLE and flushes all FIFOs
- k_size  in  K_BITS  kernel edge; kernel load = k_size*k_size beats
- m_size  in  M_BITS  beats per row
- n_rows  in  M_BITS  rows per frame
- img_vld  in  LANES  per-lane input valid
- img_data  in  LANES*DW  lane i at bits [i*DW +: DW]
- img_rdy  out  LANES  per-lane ready (FIFO not full)
- chain_cfg  out  1  high throughout CFG
- chain_cfg_done  in  1  chain configuration complete
- kernel_load  out  1  registered; qualifies chain_vld beats as kernel words
- chain_vld  out  LANES  registered; all bits equal
- chain_data  out  LANES*DW  registered lane-aligned beat
- chain_stall  in  1  chain cannot accept this cycle
- row_done  out  1  pulse after last beat of each row
- frame_done  out  1  pulse on RUN→IDLE
- busy  out  1  state ≠ IDLE

## Operation
- Per-lane FIFO: write on img_vld[i] & img_rdy[i]; img_rdy[i] = count_i < FIFO_DEPTH, combinational from count. Writes are accepted in every state, including IDLE prefetch.
- Pop condition `go`: state ∈ {KLOAD, RUN}, every FIFO non-empty, and !chain_stall. A pop reads all lanes in the same cycle. A simultaneous push and pop on a full FIFO is legal; count is unchanged.
- FSM:
  - IDLE → CFG on start.
  - CFG: chain_cfg=1. On chain_cfg_done, go to KLOAD, or to RUN if k_size==0.
  - KLOAD: kernel counter (2*K_BITS) counts pops. At k_size*k_size pops, go to RUN.
  - RUN: column counter (M_BITS) counts pops and wraps at m_size, pulsing row_done. The row counter increments on each wrap. At n_rows rows, go to IDLE and pulse frame_done.
  - RUN entered with m_size==0 or n_rows==0 goes to IDLE in one cycle with frame_done and no row_done.
- abort in any state:
  - Next state is IDLE and all FIFO pointers clear.
  - Counters clear. No frame_done is produced.
  - abort takes priority over start and over go in the same cycle.
- Reset values: all outputs 0 except img_rdy. img_rdy = all-ones one cycle after arst deasserts (FIFOs empty). Reset forces IDLE with empty FIFOs at any point mid-operation.

## Timing
- Push at cycle t → data poppable at t+1 → chain_vld/chain_data at t+2.
- One aligned beat per cycle sustained when all lanes stream and there is no stall.
- chain_stall is sampled combinationally in the go cycle. chain_vld is a one-cycle pulse per pop; there is no output holding.
- kernel_load is registered alongside chain_vld: it is 1 for beats popped in KLOAD and 0 for beats popped in RUN.
- row_done and frame_done are registered with the final beat's chain_vld (same cycle).
- chain_cfg is asserted the cycle after start and drops the cycle after chain_cfg_done is seen.

## Configuration
- DCNN_S1_INGRESS_PERF_EN defined:
  - Adds output `stall_cycles` (32 bits), cleared on start.
  - Counts cycles in KLOAD/RUN where go=0 due to chain_stall or any empty lane; saturates at all-ones.
  - Adds `lane_starve` (LANES bits), registered per-lane empty flags, for debug.
- Undefined: neither port exists and no counter logic is built.

## Structure
- Shared package dcnn_pkg:
  - Enum typedef s1_ingress_state_t {IDLE, CFG, KLOAD, RUN}.
  - Localparam helper for FIFO pointer width, clog2(FIFO_DEPTH).
- One sub-module dcnn_lane_fifo (DW, FIFO_DEPTH): push/pop, count, full/empty, synchronous flush, async active-high reset. It is instantiated LANES times in a generate loop.
- FSM and counters live in the top.

## Test plan
- LANES=2, k_size=3, m_size=4, n_rows=2, all lanes streaming with no stall → 9 beats with kernel_load=1, then 8 beats with kernel_load=0; row_done after beats 13 and 17; frame_done with beat 17.
- Lane 1 held invalid for 5 cycles mid-RUN while lane 0 fills → no chain_vld for those cycles; img_rdy[0] drops after 4 writes; no beat is lost or misaligned after lane 1 resumes.
- chain_stall toggled every other cycle during RUN → chain_vld only on non-stall cycles; beat order matches input order.
- k_size=0, m_size=0 → CFG→RUN→IDLE with frame_done and no chain_vld.
- abort asserted after 5 KLOAD beats with FIFOs non-empty → IDLE next cycle, img_rdy all-ones the cycle after, no frame_done; a new start then replays the sequence cleanly.
- arst pulsed mid-RUN → all outputs 0 and busy=0 during reset; with PERF_EN defined, stall_cycles equals the count of injected stall cycles in the first scenario repeated with stalls.
